// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the RX and TX sides:
// FSM state encoding, default line parameters and the baud divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

    localparam int UART_CLK_FREQ   = 90000000;
    localparam int UART_BAUD       = 9600;
    localparam int UART_OVERSAMPLE = 16;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
        return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on DIV-1.
// Holding en low parks the counter at 0 so the phase restarts from the enable edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = UART_CLK_FREQ,
    parameter int BAUD       = UART_BAUD,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic tick
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receive front end: synchronises rxd, majority-votes three mid-bit samples,
// deframes the byte and presents it with a sticky ready flag plus error/overrun pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = UART_CLK_FREQ,
    parameter int BAUD       = UART_BAUD,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    input  logic       rx_clear,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_idle
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int SW = $clog2(OVERSAMPLE);

    uart_state_t r_state, w_state_nxt;

    logic          r_rxd_meta, r_rxd_s;
    logic [SW-1:0] r_s, w_s_next;
    logic [2:0]    r_bit;
    logic [1:0]    r_smp;
    logic [7:0]    r_shift, r_data;
    logic          r_ready, r_ferr, r_ovr;

    logic w_en, w_tick, w_wrap, w_vote_evt, w_vote;
    logic w_shift_en, w_capture, w_ferr;

    assign w_en = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk    (clk),
        .resetn (resetn),
        .en     (w_en),
        .tick   (w_tick)
    );

    assign w_s_next   = (r_s == SW'(OVERSAMPLE - 1)) ? '0 : r_s + SW'(1);
    assign w_wrap     = w_tick && (r_s == SW'(OVERSAMPLE - 1));
    // The vote resolves on the tick that takes s to M+1; rxd_s is the third sample.
    assign w_vote_evt = w_tick && (r_s == SW'(M));
    assign w_vote     = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rxd_s) | (r_smp[1] & r_rxd_s);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_capture   = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rxd_s) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_vote_evt && w_vote) w_state_nxt = ST_IDLE;
                else if (w_wrap)          w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_shift_en = w_vote_evt;
                if (w_wrap && (r_bit == 3'd7)) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_vote_evt) begin
                    if (w_vote) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (r_rxd_s) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_s        <= '0;
            r_bit      <= 3'd0;
            r_smp      <= 2'b11;
            r_shift    <= 8'h00;
            r_data     <= 8'h00;
            r_ready    <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;

            if (!w_en) begin
                r_s <= '0;
            end else if (w_tick) begin
                r_s <= w_s_next;
            end

            if (w_tick && (r_s == SW'(M - 2))) r_smp[0] <= r_rxd_s;
            if (w_tick && (r_s == SW'(M - 1))) r_smp[1] <= r_rxd_s;

            if (r_state != ST_DATA) begin
                r_bit <= 3'd0;
            end else if (w_wrap) begin
                r_bit <= r_bit + 3'd1;
            end

            if (w_shift_en) r_shift <= {w_vote, r_shift[7:1]};
            if (w_capture)  r_data  <= r_shift;

            // Set beats clear when both land in the same cycle.
            if (w_capture) begin
                r_ready <= 1'b1;
            end else if (rx_clear) begin
                r_ready <= 1'b0;
            end

            r_ferr <= w_ferr;
            r_ovr  <= w_capture && r_ready && !rx_clear;
        end
    end

    assign rx_ready     = r_ready;
    assign rx_data      = r_data;
    assign rx_frame_err = r_ferr;
    assign rx_overrun   = r_ovr;
    assign rx_idle      = (r_state == ST_IDLE) && r_rxd_s;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 1.6 MHz / 10 kbaud / x16 (DIV=10, 160 clk per bit).
module tb_uart_rx_core;

    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_clear;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_idle;

    logic tie_clr = 1'b1;
    logic clr_m   = 1'b0;
    assign rx_clear = tie_clr ? rx_ready : clr_m;

    uart_rx_core #(
        .CLK_FREQ   (1600000),
        .BAUD       (10000),
        .OVERSAMPLE (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rxd          (rxd),
        .rx_clear     (rx_clear),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_idle      (rx_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_rdy = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         rdy_cyc = 0;
    int         start_cyc = 0;
    logic       prev_rdy = 1'b0;
    logic [7:0] rx_log [16];

    // Monitor samples mid-high phase; stimulus and checks run on negedges.
    always begin
        @(posedge clk);
        #2;
        if (rx_ready && !prev_rdy) begin
            if (n_rdy < 16) rx_log[n_rdy] = rx_data;
            n_rdy   = n_rdy + 1;
            rdy_cyc = cyc;
        end
        if (rx_frame_err) n_ferr = n_ferr + 1;
        if (rx_overrun)   n_ovr  = n_ovr + 1;
        prev_rdy = rx_ready;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int bclk, input logic stop);
        start_cyc = cyc;
        rxd = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (bclk) @(negedge clk);
        end
        rxd = stop;
        repeat (bclk) @(negedge clk);
    endtask

    function automatic logic [7:0] log_at(input int idx);
        if (idx >= 0 && idx < 16) return rx_log[idx];
        return 8'hxx;
    endfunction

    int b_rdy, b_ferr, b_ovr;

    initial begin
        resetn = 1'b0;
        rxd    = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_ready", rx_ready, 0);
        check_val("rst_data", rx_data, 8'h00);
        check_val("rst_ferr", rx_frame_err, 0);
        check_val("rst_ovr", rx_overrun, 0);
        check_val("rst_idle", rx_idle, 1);
        resetn = 1'b1;
        repeat (20) @(negedge clk);

        // Clean 0xA5, rx_clear tied to rx_ready.
        send_byte(8'hA5, BIT, 1'b1);
        repeat (200) @(negedge clk);
        check_val("a5_count", n_rdy, 1);
        check_val("a5_data", log_at(0), 8'hA5);
        check_val("a5_latency", rdy_cyc - start_cyc, 1533);
        check_val("a5_ready_cleared", rx_ready, 0);
        check_val("a5_ferr", n_ferr, 0);
        check_val("a5_ovr", n_ovr, 0);

        // 40-clk low glitch: rejected at the start-bit vote.
        b_rdy = n_rdy; b_ferr = n_ferr; b_ovr = n_ovr;
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        check_val("glitch_busy", rx_idle, 0);
        repeat (47) @(negedge clk);
        check_val("glitch_idle", rx_idle, 1);
        repeat (200) @(negedge clk);
        check_val("glitch_rdy", n_rdy - b_rdy, 0);
        check_val("glitch_flags", (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);

        // 0x3C with low stop bit, then a held break.
        b_rdy = n_rdy; b_ferr = n_ferr;
        send_byte(8'h3C, BIT, 1'b0);
        repeat (1000) @(negedge clk);
        check_val("ferr_pulse", n_ferr - b_ferr, 1);
        check_val("ferr_no_rdy", n_rdy - b_rdy, 0);
        check_val("ferr_ready", rx_ready, 0);
        check_val("ferr_data", rx_data, 8'hA5);
        check_val("break_busy", rx_idle, 0);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        check_val("break_release", rx_idle, 1);
        repeat (100) @(negedge clk);

        // Overrun: no clear between 0x11 and 0x22.
        tie_clr = 1'b0;
        clr_m   = 1'b0;
        b_ovr = n_ovr; b_ferr = n_ferr;
        send_byte(8'h11, BIT, 1'b1);
        repeat (100) @(negedge clk);
        check_val("ovr_first_ready", rx_ready, 1);
        check_val("ovr_first_data", rx_data, 8'h11);
        send_byte(8'h22, BIT, 1'b1);
        repeat (100) @(negedge clk);
        check_val("ovr_ready", rx_ready, 1);
        check_val("ovr_data", rx_data, 8'h22);
        check_val("ovr_pulse", n_ovr - b_ovr, 1);
        check_val("ovr_no_ferr", n_ferr - b_ferr, 0);
        clr_m = 1'b1;
        @(negedge clk);
        clr_m = 1'b0;
        @(negedge clk);
        check_val("clear_ready", rx_ready, 0);

        // Clear arriving in the capture cycle of a second byte: set wins.
        send_byte(8'h33, BIT, 1'b1);
        repeat (100) @(negedge clk);
        check_val("sw_first_ready", rx_ready, 1);
        b_ovr = n_ovr;
        fork
            send_byte(8'h44, BIT, 1'b1);
            begin
                repeat (1532) @(negedge clk);
                clr_m = 1'b1;
                @(negedge clk);
                clr_m = 1'b0;
            end
        join
        check_val("sw_ready", rx_ready, 1);
        check_val("sw_data", rx_data, 8'h44);
        check_val("sw_no_ovr", n_ovr - b_ovr, 0);
        clr_m = 1'b1;
        @(negedge clk);
        clr_m = 1'b0;
        tie_clr = 1'b1;
        repeat (100) @(negedge clk);

        // Bit-rate tolerance, back-to-back frames.
        b_rdy = n_rdy; b_ferr = n_ferr; b_ovr = n_ovr;
        send_byte(8'h00, 155, 1'b1);
        send_byte(8'hFF, 165, 1'b1);
        repeat (200) @(negedge clk);
        check_val("tol_count", n_rdy - b_rdy, 2);
        check_val("tol_data0", log_at(b_rdy), 8'h00);
        check_val("tol_data1", log_at(b_rdy + 1), 8'hFF);
        check_val("tol_flags", (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);

        // Reset mid-byte, then a clean frame.
        rxd = 1'b0;
        repeat (1400) @(negedge clk);
        check_val("mid_busy", rx_idle, 0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check_val("mid_rst_ready", rx_ready, 0);
        check_val("mid_rst_data", rx_data, 8'h00);
        check_val("mid_rst_idle", rx_idle, 1);
        check_val("mid_rst_flags", {30'd0, rx_frame_err, rx_overrun}, 0);
        b_rdy = n_rdy; b_ferr = n_ferr; b_ovr = n_ovr;
        repeat (39) @(negedge clk);
        rxd = 1'b1;
        repeat (300) @(negedge clk);
        check_val("post_rst_no_rdy", n_rdy - b_rdy, 0);
        send_byte(8'h5A, BIT, 1'b1);
        repeat (200) @(negedge clk);
        check_val("post_rst_count", n_rdy - b_rdy, 1);
        check_val("post_rst_data", log_at(b_rdy), 8'h5A);
        check_val("post_rst_flags", (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
